// File: rtl/pc_predict_unit.sv
// Fetch program counter with a direct-mapped BTB of 2-bit saturating counters.
// Execute-stage resolution trains the BTB and redirects fetch when a prediction was wrong.
module pc_predict_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_cfi,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] imemaddr,
    output logic [31:0] pc_plus4,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush
);
    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [31:0]     pc_q, pc_d;
    logic            valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [29:0]     target_q [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];

    logic [IDXW-1:0] fetch_idx, ex_idx;
    logic [TAGW-1:0] fetch_tag, ex_tag;
    logic            fetch_hit, ex_hit, btb_upd;
    logic            dir_wrong, tgt_wrong;
    logic [31:0]     redirect_pc;
    logic            unused_bits;

    // Lookup path: reads the BTB as it stood before this edge's update.
    assign fetch_idx   = pc_q[IDXW+1:2];
    assign fetch_tag   = pc_q[31:IDXW+2];
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign imemaddr    = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_target = fetch_hit ? {target_q[fetch_idx], 2'b00} : pc_plus4;

    assign ex_idx  = ex_pc[IDXW+1:2];
    assign ex_tag  = ex_pc[31:IDXW+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign btb_upd = ex_valid && ex_cfi;

    assign dir_wrong   = ex_taken != ex_pred_taken;
    assign tgt_wrong   = ex_taken && (ex_target[31:2] != ex_pred_target[31:2]);
    assign flush       = btb_upd && (dir_wrong || tgt_wrong);
    assign redirect_pc = ex_taken ? {ex_target[31:2], 2'b00} : {ex_pc[31:2] + 30'd1, 2'b00};

    // Low address bits carry no information for word-aligned control flow.
    assign unused_bits = ^{ex_pc[1:0], ex_target[1:0], ex_pred_target[1:0]};

    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ihit) begin
            pc_d = pred_taken ? pred_target : pc_plus4;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= PC_INIT;
        end else begin
            pc_q <= pc_d;
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic       sel;
            logic [1:0] ctr_inc, ctr_dec;

            assign sel     = btb_upd && (ex_idx == IDXW'(gi));
            assign ctr_inc = (ctr_q[gi] == 2'b11) ? 2'b11 : ctr_q[gi] + 2'b01;
            assign ctr_dec = (ctr_q[gi] == 2'b00) ? 2'b00 : ctr_q[gi] - 2'b01;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= 2'b01;
                end else if (sel) begin
                    if (ex_hit) begin
                        if (ex_taken) begin
                            ctr_q[gi]    <= ctr_inc;
                            target_q[gi] <= ex_target[31:2];
                        end else begin
                            ctr_q[gi]    <= ctr_dec;
                        end
                    end else if (ex_taken) begin
                        valid_q[gi]  <= 1'b1;
                        tag_q[gi]    <= ex_tag;
                        target_q[gi] <= ex_target[31:2];
                        ctr_q[gi]    <= 2'b10;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural BTB/PC model.
module tb_pc_predict_unit;
    localparam int N  = 4;
    localparam int IW = 2;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, ex_valid, ex_cfi, ex_taken, ex_pred_taken;
    logic [31:0] ex_target, ex_pc, ex_pred_target;
    logic [31:0] imemaddr, pc_plus4, pred_target;
    logic        pred_taken, flush;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    pc_predict_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(N)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall),
        .ex_valid(ex_valid), .ex_cfi(ex_cfi), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .imemaddr(imemaddr), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .pred_target(pred_target), .flush(flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: each entry remembers the full branch PC and full target.
    logic [31:0] m_pc;
    bit          m_v   [N];
    logic [31:0] m_bpc [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (2 + IW);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && (tag_of(m_bpc[idx_of(pc)]) == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken();
        return m_hit(m_pc) && (m_ctr[idx_of(m_pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target();
        return m_hit(m_pc) ? (m_tgt[idx_of(m_pc)] & ~32'd3) : m_pc + 32'd4;
    endfunction

    function automatic bit m_flush();
        if (!(ex_valid && ex_cfi)) return 1'b0;
        if (ex_taken != ex_pred_taken) return 1'b1;
        return ex_taken && ((ex_target >> 2) != (ex_pred_target >> 2));
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0; m_bpc[i] = 32'h0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
    endtask

    task automatic clr();
        RST = 0; ihit = 0; stall = 0; ex_valid = 0; ex_cfi = 0; ex_taken = 0;
        ex_pred_taken = 0; ex_target = 0; ex_pc = 0; ex_pred_target = 0;
    endtask

    // Compare outputs with the model, then advance both through one clock edge.
    task automatic cycle();
        logic [31:0] nxt;
        int          i;
        #1;
        check_eq("imemaddr", imemaddr, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("pred_taken", pred_taken, m_pred_taken());
        check_eq("pred_target", pred_target, m_pred_target());
        check_eq("flush", flush, m_flush());
        if (m_flush())   nxt = ex_taken ? (ex_target & ~32'd3) : ((ex_pc + 32'd4) & ~32'd3);
        else if (stall)  nxt = m_pc;
        else if (ihit)   nxt = m_pred_taken() ? m_pred_target() : m_pc + 32'd4;
        else             nxt = m_pc;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (ex_valid && ex_cfi) begin
                i = idx_of(ex_pc);
                if (m_hit(ex_pc)) begin
                    if (ex_taken) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = ex_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (ex_taken) begin
                    m_v[i] = 1'b1; m_bpc[i] = ex_pc; m_tgt[i] = ex_target; m_ctr[i] = 2;
                end
            end
            m_pc = nxt;
        end
        @(negedge CLK);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        clr();
        ex_valid = 1; ex_cfi = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
        cycle();
        clr();
    endtask

    // Not-taken mispredict at addr-4 steers fetch to addr.
    task automatic redirect_to(input logic [31:0] addr);
        resolve(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clr();
        RST = 1;
        @(posedge CLK);
        @(negedge CLK);
        model_reset();
        cycle();
        check_eq("reset_pc", imemaddr, 32'h0);
        check_eq("reset_pred", pred_taken, 1'b0);
        check_eq("reset_tgt", pred_target, 32'h4);
        RST = 0;

        // Sequential fetch
        for (int k = 1; k <= 4; k++) begin
            ihit = 1;
            cycle();
            check_eq("seq_pc", imemaddr, 32'(k * 4));
            check_eq("seq_pred", pred_taken, 1'b0);
        end

        // Stall then no-ihit hold
        for (int k = 0; k < 5; k++) begin
            ihit = (k < 3); stall = (k < 3);
            cycle();
            check_eq("hold_pc", imemaddr, 32'h10);
        end
        clr();

        // Taken mispredict allocates, then predicts
        ex_valid = 1; ex_cfi = 1; ex_pc = 32'h8; ex_taken = 1; ex_target = 32'h40;
        #1 check_eq("alloc_flush", flush, 1'b1);
        cycle();
        clr();
        check_eq("alloc_redirect", imemaddr, 32'h40);
        redirect_to(32'h8);
        check_eq("pred_after_alloc", pred_taken, 1'b1);
        check_eq("pred_tgt_after_alloc", pred_target, 32'h40);
        ihit = 1;
        cycle();
        clr();
        check_eq("follow_pred", imemaddr, 32'h40);

        // Counter hysteresis: 10 -> 01 -> 10 -> 11 -> 10
        resolve(32'h8, 1'b0, 32'h0, 1'b1, 32'h40);
        redirect_to(32'h8);
        check_eq("ctr01_pred", pred_taken, 1'b0);
        resolve(32'h8, 1'b1, 32'h40, 1'b0, 32'h0);
        resolve(32'h8, 1'b1, 32'h40, 1'b0, 32'h0);
        resolve(32'h8, 1'b0, 32'h0, 1'b1, 32'h40);
        redirect_to(32'h8);
        check_eq("ctr10_pred", pred_taken, 1'b1);

        // Not-taken mispredict overrides stall
        ex_valid = 1; ex_cfi = 1; ex_pc = 32'h8; ex_pred_taken = 1; ex_pred_target = 32'h40;
        stall = 1;
        #1 check_eq("nt_flush", flush, 1'b1);
        cycle();
        clr();
        check_eq("nt_redirect", imemaddr, 32'hC);

        // Aliasing: 0x18 evicts 0x8
        resolve(32'h18, 1'b1, 32'h80, 1'b0, 32'h0);
        redirect_to(32'h8);
        check_eq("alias_pred", pred_taken, 1'b0);
        check_eq("alias_tgt", pred_target, 32'hC);

        // Wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        check_eq("wrap_start", imemaddr, 32'hFFFF_FFFC);
        ihit = 1;
        cycle();
        clr();
        check_eq("wrap_pc", imemaddr, 32'h0);

        // Reset beats a simultaneous mispredict and BTB write
        RST = 1; ihit = 1; ex_valid = 1; ex_cfi = 1; ex_pc = 32'h8; ex_taken = 1; ex_target = 32'h40;
        cycle();
        clr();
        check_eq("rst_pri_pc", imemaddr, 32'h0);
        redirect_to(32'h8);
        check_eq("rst_pri_pred", pred_taken, 1'b0);
        check_eq("rst_pri_tgt", pred_target, 32'hC);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            RST = ($urandom_range(0, 63) == 0);
            ihit = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            ex_valid = $urandom_range(0, 1);
            ex_cfi = ($urandom_range(0, 3) != 0);
            ex_taken = $urandom_range(0, 1);
            ex_pc = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 31) << 2);
            ex_target = 32'($urandom_range(0, 31) << 2) | 32'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0);
            ex_pred_taken = ($urandom_range(0, 3) != 0) ? ex_taken : ~ex_taken;
            ex_pred_target = ($urandom_range(0, 3) != 0) ? ex_target : 32'($urandom_range(0, 31) << 2);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised program counter unit for the pipelined datapath. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can redirect speculatively to a predicted target. Control-flow resolution from the execute stage corrects any mispredict. The unit sits at the front of the fetch stage, drives the instruction memory address, and supplies per-fetch prediction metadata that travels down the pipeline with the instruction.

## Interface

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
- BTB_ENTRIES, 4, number of BTB entries; power of two, 2..64. IDXW = log2(BTB_ENTRIES).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returned the word at imemaddr this cycle.
- stall  in  1  hazard unit freezes fetch.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_cfi  in  1  that instruction is a branch or jump (beq/bne/j/jal/jr).
- ex_taken  in  1  resolved direction (always 1 for jumps).
- ex_target  in  32  resolved target when taken.
- ex_pc  in  32  PC of the execute-stage instruction.
- ex_pred_taken  in  1  prediction recorded at fetch for that instruction.
- ex_pred_target  in  32  predicted target recorded at fetch.
- imemaddr  out  32  current fetch PC.
- pc_plus4  out  32  imemaddr + 4.
- pred_taken  out  1  BTB predicts the instruction at imemaddr is taken.
- pred_target  out  32  BTB target; valid when pred_taken = 1.
- flush  out  1  mispredict detected; younger instructions must be squashed.

## Operation

- BTB entry fields: valid, tag = pc[31:IDXW+2], target[31:2], ctr[1:0]. Index = pc[IDXW+1:2].
- Lookup is combinational on imemaddr. Hit = valid and tag match. pred_taken = hit and ctr[1]. pred_target = {target, 2'b00}. On a miss, pred_target = pc_plus4.
- Mispredict occurs when ex_valid and ex_cfi are both set and one of these holds:
  - ex_taken != ex_pred_taken;
  - ex_taken and ex_target[31:2] != ex_pred_target[31:2].
- flush is asserted combinationally on a mispredict. The redirect PC is ex_taken ? ex_target : ex_pc + 4, with bits [1:0] forced to 0.
- Next-PC priority, highest first:
  1. RST: load PC_INIT.
  2. Mispredict: load redirect PC. This applies regardless of stall or ihit.
  3. stall: hold.
  4. ihit: load pred_taken ? pred_target : pc_plus4.
  5. Otherwise: hold.
- BTB update occurs on ex_valid & ex_cfi, independent of stall. The entry is selected by ex_pc.
  - Hit, taken: ctr saturating-increments (max 2'b11); target is written with ex_target.
  - Hit, not taken: ctr saturating-decrements (min 2'b00); target is unchanged.
  - Miss, taken: allocate the entry, overwriting it. Set valid=1, tag from ex_pc, target from ex_target, ctr=2'b10.
  - Miss, not taken: no change.
- Arithmetic is modulo 2^32. PC+4 from 32'hFFFFFFFC wraps to 0.

## Timing

- Reset values:
  - imemaddr = PC_INIT, so pc_plus4 = PC_INIT+4.
  - All valid bits = 0 and ctr = 2'b01, so pred_taken = 0 and pred_target = pc_plus4.
  - flush is a combinational function of ex_* inputs. The bench holds ex_valid = 0 during reset.
- imemaddr is registered. A new PC appears one cycle after the qualifying edge. A redirect reaches imemaddr on the edge in the cycle flush is high.
- A BTB write becomes visible to lookup on the cycle after the edge. If lookup and update hit the same index in the same cycle, lookup uses the pre-update contents.
- RST asserted mid-operation wins over a simultaneous mispredict, ihit, or BTB update: no BTB write occurs on that edge.
- ihit = 0 with no mispredict: imemaddr and the BTB lookup outputs hold steady.

## Test plan

- Reset and sequential fetch: PC_INIT = 32'h0, RST for 2 cycles, then ihit = 1 for 4 cycles. Required: imemaddr runs 0, 4, 8, 0xC, 0x10; pred_taken = 0 throughout.
- Stall and ihit gating: at PC 0x10, stall = 1 for 3 cycles with ihit = 1, then stall = 0 and ihit = 0 for 2 cycles. Required: imemaddr holds 0x10 for all 5 cycles.
- Mispredict allocate then predict (BTB_ENTRIES = 4):
  - Resolve a taken branch with ex_pc = 0x8, ex_target = 0x40, ex_pred_taken = 0. Required: flush = 1 and the next imemaddr = 0x40.
  - Later fetch 0x8. Required: pred_taken = 1, pred_target = 0x40, and after ihit, imemaddr = 0x40.
- Counter hysteresis:
  - From ctr = 2'b10, resolve not-taken at 0x8. Required: ctr = 01, so fetch at 0x8 predicts not-taken.
  - Resolve taken twice. Required: ctr = 11.
  - Resolve one not-taken. Required: ctr = 10, still predicts taken.
- Not-taken mispredict redirect: ex_pc = 0x8, ex_pred_taken = 1, ex_taken = 0, with stall = 1 at the same time. Required: flush = 1 and the next imemaddr = 0xC, since the redirect overrides stall.
- Aliasing, wrap and reset priority:
  - Entries for 0x8 and 0x18 share an index. A taken branch at 0x18 replaces the 0x8 entry; fetching 0x8 must then give pred_taken = 0.
  - A PC at 32'hFFFFFFFC with ihit must go to 0.
  - RST asserted together with a mispredict must give imemaddr = PC_INIT and an all-invalid BTB.
